// File: rtl/pixel_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_writer_pkg
//  Description : Shared types and default geometry for the pixel writer.
//                Holds the frame-control state encoding and the default
//                framebuffer dimensions / address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pixel_writer_pkg;

    // Frame-control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pw_state_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_ADDR_W   = 19;

endpackage : pixel_writer_pkg
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo
//  Description : Synchronous pending-write buffer with a registered output
//                stage. DEPTH storage entries feed a single output register
//                that drives the consumer directly, so the presented word is
//                held stable while the consumer stalls.
//  Ports       : clk, rst_n     - clock, synchronous active-low reset
//                clear          - synchronous flush (new frame)
//                push/push_data - write side; push ignored when full
//                full           - storage entries all occupied
//                empty          - storage and output register both empty
//                out_valid/out_data/out_ready - registered read side
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic load_out;
    logic do_pop;
    logic do_push;

    // The output register can take a new word when it is empty or its
    // current word is being consumed this cycle.
    assign load_out = !out_valid || out_ready;
    assign do_pop   = load_out && (count != '0);
    assign do_push  = push && !full;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0) && !out_valid;

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leave occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load_out) begin
                out_valid <= (count != '0);
                if (count != '0) begin
                    out_data <= store[rd_ptr];
                end
            end
        end
    end

endmodule : pixel_fifo
`default_nettype wire

// File: rtl/pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_writer
//  Description : Accepts signed (x,y) pixels from a shape generator, clips
//                them to the framebuffer, and issues ordered memory writes of
//                a per-frame latched color through a small pending buffer.
//  Ports       : _clock, _reset_n      - clock, synchronous active-low reset
//                _start, color         - begin frame, latch color
//                _in_x/_in_y/_in_valid/_in_ready/_in_done - pixel stream
//                mem_addr/mem_data/mem_valid/mem_ready    - write port
//                written, clipped      - per-frame saturating counters
//                _done                 - frame complete (held until _start)
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              _clock,
    input  logic              _reset_n,
    input  logic              _start,
    input  logic [7:0]        color,
    input  logic [31:0]       _in_x,
    input  logic [31:0]       _in_y,
    input  logic              _in_valid,
    output logic              _in_ready,
    input  logic              _in_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [31:0]       written,
    output logic [31:0]       clipped,
    output logic              _done
);

    generate
        if ((64'd1 << ADDR_W) < (64'(SCREEN_W) * 64'(SCREEN_H))) begin : g_addr_w_check
            $error("pixel_writer: ADDR_W too small for SCREEN_W*SCREEN_H");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
            $error("pixel_writer: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    pw_state_t state;
    pw_state_t next_state;

    logic [7:0]        color_q;
    logic              start_go;
    logic              accept;
    logic              in_bounds;
    logic [ADDR_W-1:0] pix_addr;
    logic              push;
    logic              clip_inc;
    logic              fifo_full;
    logic              fifo_empty;

    // _start is honoured only between frames.
    assign start_go = _start && ((state == ST_IDLE) || (state == ST_DONE));

    // Depends only on registered state, never on the pixel inputs.
    assign _in_ready = (state == ST_RUN) && !fifo_full;
    assign accept    = _in_valid && _in_ready;

    assign in_bounds = ($signed(_in_x) >= 32'sd0) && ($signed(_in_x) < SCREEN_W) &&
                       ($signed(_in_y) >= 32'sd0) && ($signed(_in_y) < SCREEN_H);

    // Computed directly at ADDR_W bits: modular arithmetic gives the same
    // low bits as the full product truncated.
    assign pix_addr = ADDR_W'(_in_y) * ADDR_W'(SCREEN_W) + ADDR_W'(_in_x);

    assign push     = accept && in_bounds;
    assign clip_inc = accept && !in_bounds;

    assign mem_data = color_q;
    assign _done    = (state == ST_DONE);

    pixel_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (_clock),
        .rst_n     (_reset_n),
        .clear     (start_go),
        .push      (push),
        .push_data (pix_addr),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .out_valid (mem_valid),
        .out_data  (mem_addr),
        .out_ready (mem_ready)
    );

    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (_start) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (_in_done && !_in_valid) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !mem_valid) begin
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            color_q <= 8'd0;
            written <= 32'd0;
            clipped <= 32'd0;
        end else if (start_go) begin
            color_q <= color;
            written <= 32'd0;
            clipped <= 32'd0;
        end else begin
            if (mem_valid && mem_ready && (written != 32'hFFFF_FFFF)) begin
                written <= written + 32'd1;
            end
            if (clip_inc && (clipped != 32'hFFFF_FFFF)) begin
                clipped <= clipped + 32'd1;
            end
        end
    end

endmodule : pixel_writer
`default_nettype wire

// File: tb/tb_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_writer
//  Description : Directed self-checking bench for pixel_writer. A monitor
//                logs every memory handshake; each scenario task compares
//                the log and counters against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  color;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        in_valid;
    logic        in_ready;
    logic        in_done;
    logic [18:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] written;
    logic [31:0] clipped;
    logic        done;

    int total;
    int bad;

    logic [18:0] log_addr[$];
    logic [7:0]  log_data[$];

    pixel_writer dut (
        ._clock    (clk),
        ._reset_n  (rst_n),
        ._start    (start),
        .color     (color),
        ._in_x     (in_x),
        ._in_y     (in_y),
        ._in_valid (in_valid),
        ._in_ready (in_ready),
        ._in_done  (in_done),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .written   (written),
        .clipped   (clipped),
        ._done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge, so the falling edge sees the
    // values the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n && mem_valid && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input int x, input int y);
        int n;
        n = 0;
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready=%0b want 1", in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] c);
        color = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        in_done = 1'b1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL frame_done_timeout done=%0b want 1", done);
        end
        in_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        color = 8'hFF;
        tick();
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        total += 7;
        if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got %0b want 0", mem_valid); end
        if (in_ready  !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
        if (done      !== 1'b0) begin bad++; $display("FAIL rst_done got %0b want 0", done); end
        if (written   !== 32'd0) begin bad++; $display("FAIL rst_written got %0d want 0", written); end
        if (clipped   !== 32'd0) begin bad++; $display("FAIL rst_clipped got %0d want 0", clipped); end
        if (mem_addr  !== 19'd0) begin bad++; $display("FAIL rst_mem_addr got %0d want 0", mem_addr); end
        if (mem_data  !== 8'd0) begin bad++; $display("FAIL rst_mem_data got %0h want 0", mem_data); end
    endtask

    task automatic test_rect();
        int base;
        int exp_addr[$];
        mem_ready = 1'b1;
        base = log_addr.size();
        start_frame(8'hA5);
        for (int x = 23; x <= 29; x++) begin send_pixel(x, 17); exp_addr.push_back(17 * 640 + x); end
        for (int x = 23; x <= 29; x++) begin send_pixel(x, 21); exp_addr.push_back(21 * 640 + x); end
        for (int y = 18; y <= 20; y++) begin
            send_pixel(23, y); exp_addr.push_back(y * 640 + 23);
            send_pixel(29, y); exp_addr.push_back(y * 640 + 29);
        end
        finish_frame();
        total++;
        if (log_addr.size() - base !== 20) begin
            bad++; $display("FAIL rect_count got %0d want 20", log_addr.size() - base);
        end else begin
            total++;
            if (log_addr[base] !== 19'd10903) begin bad++; $display("FAIL rect_first_addr got %0d want 10903", log_addr[base]); end
            for (int i = 0; i < 20; i++) begin
                total++;
                if (log_addr[base + i] !== 19'(exp_addr[i]) || log_data[base + i] !== 8'hA5) begin
                    bad++;
                    $display("FAIL rect_write[%0d] got addr=%0d data=%0h want addr=%0d data=a5",
                             i, log_addr[base + i], log_data[base + i], exp_addr[i]);
                end
            end
        end
        total += 3;
        if (written !== 32'd20) begin bad++; $display("FAIL rect_written got %0d want 20", written); end
        if (clipped !== 32'd0)  begin bad++; $display("FAIL rect_clipped got %0d want 0", clipped); end
        if (done    !== 1'b1)   begin bad++; $display("FAIL rect_done got %0b want 1", done); end
        repeat (3) tick();
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL done_hold got %0b want 1", done); end
    endtask

    task automatic test_clip();
        int base;
        mem_ready = 1'b1;
        base = log_addr.size();
        start_frame(8'h3C);
        send_pixel(-1, 0);
        send_pixel(640, 0);
        send_pixel(0, 480);
        send_pixel(639, 479);
        finish_frame();
        total += 3;
        if (log_addr.size() - base !== 1) begin
            bad++; $display("FAIL clip_count got %0d want 1", log_addr.size() - base);
        end else if (log_addr[base] !== 19'd307199 || log_data[base] !== 8'h3C) begin
            bad++; $display("FAIL clip_write got addr=%0d data=%0h want addr=307199 data=3c", log_addr[base], log_data[base]);
        end
        if (clipped !== 32'd3) begin bad++; $display("FAIL clip_clipped got %0d want 3", clipped); end
        total++;
        if (written !== 32'd1) begin bad++; $display("FAIL clip_written got %0d want 1", written); end
    endtask

    task automatic test_backpressure();
        int px[6];
        int py[6];
        int ea[6];
        int idx;
        int base;
        int n;
        logic acc;
        logic seen;
        logic stable_ok;
        logic [18:0] first;
        px = '{10, 11, 12, 0, 5, 639};
        py = '{3, 3, 3, 1, 2, 0};
        ea = '{1930, 1931, 1932, 640, 1285, 639};
        mem_ready = 1'b0;
        base = log_addr.size();
        start_frame(8'h5A);
        idx = 0;
        seen = 1'b0;
        stable_ok = 1'b1;
        first = '0;
        in_x = px[0]; in_y = py[0]; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            acc = in_ready;
            tick();
            if (acc) idx++;
            if (idx < 6) begin in_x = px[idx]; in_y = py[idx]; end
            else in_valid = 1'b0;
            if (mem_valid) begin
                if (!seen) begin first = mem_addr; seen = 1'b1; end
                else if (mem_addr !== first) stable_ok = 1'b0;
            end
        end
        total += 6;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
        if (idx >= 6) begin bad++; $display("FAIL bp_accepted got %0d want <6", idx); end
        if (mem_valid !== 1'b1) begin bad++; $display("FAIL bp_mem_valid got %0b want 1", mem_valid); end
        if (first !== 19'd1930) begin bad++; $display("FAIL bp_head_addr got %0d want 1930", first); end
        if (stable_ok !== 1'b1) begin bad++; $display("FAIL bp_addr_stable got %0b want 1", stable_ok); end
        if (log_addr.size() !== base) begin bad++; $display("FAIL bp_no_write got %0d want 0", log_addr.size() - base); end
        mem_ready = 1'b1;
        n = 0;
        while (idx < 6 && n < 50) begin
            acc = in_ready;
            tick();
            n++;
            if (acc) idx++;
            if (idx < 6) begin in_x = px[idx]; in_y = py[idx]; end
        end
        in_valid = 1'b0;
        finish_frame();
        total++;
        if (log_addr.size() - base !== 6) begin
            bad++; $display("FAIL bp_count got %0d want 6", log_addr.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (log_addr[base + i] !== 19'(ea[i]) || log_data[base + i] !== 8'h5A) begin
                    bad++;
                    $display("FAIL bp_write[%0d] got addr=%0d data=%0h want addr=%0d data=5a",
                             i, log_addr[base + i], log_data[base + i], ea[i]);
                end
            end
        end
        total++;
        if (written !== 32'd6) begin bad++; $display("FAIL bp_written got %0d want 6", written); end
    endtask

    task automatic test_reset_mid();
        int base;
        mem_ready = 1'b0;
        start_frame(8'h11);
        send_pixel(1, 1);
        send_pixel(2, 2);
        send_pixel(3, 3);
        send_pixel(-5, 0);
        tick();
        total += 2;
        if (clipped !== 32'd1) begin bad++; $display("FAIL rm_pre_clipped got %0d want 1", clipped); end
        if (mem_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_mem_valid got %0b want 1", mem_valid); end
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        total += 7;
        if (mem_valid !== 1'b0) begin bad++; $display("FAIL rm_mem_valid got %0b want 0", mem_valid); end
        if (written !== 32'd0)  begin bad++; $display("FAIL rm_written got %0d want 0", written); end
        if (clipped !== 32'd0)  begin bad++; $display("FAIL rm_clipped got %0d want 0", clipped); end
        if (in_ready !== 1'b0)  begin bad++; $display("FAIL rm_in_ready got %0b want 0", in_ready); end
        if (done !== 1'b0)      begin bad++; $display("FAIL rm_done got %0b want 0", done); end
        if (mem_addr !== 19'd0) begin bad++; $display("FAIL rm_mem_addr got %0d want 0", mem_addr); end
        if (mem_data !== 8'd0)  begin bad++; $display("FAIL rm_mem_data got %0h want 0", mem_data); end
        base = log_addr.size();
        mem_ready = 1'b1;
        repeat (6) tick();
        total += 2;
        if (log_addr.size() !== base) begin bad++; $display("FAIL rm_no_write got %0d want 0", log_addr.size() - base); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_idle got in_ready=%0b want 0", in_ready); end
    endtask

    task automatic test_empty();
        int n;
        mem_ready = 1'b1;
        start_frame(8'h22);
        in_done = 1'b1;
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        in_done = 1'b0;
        total += 2;
        if (!(done === 1'b1 && n <= 2)) begin bad++; $display("FAIL empty_done got done=%0b cycles=%0d want 1 within 2", done, n); end
        if (written !== 32'd0) begin bad++; $display("FAIL empty_written got %0d want 0", written); end
    endtask

    task automatic test_start_in_run();
        int base;
        mem_ready = 1'b1;
        base = log_addr.size();
        start_frame(8'h77);
        send_pixel(4, 4);
        send_pixel(-1, -1);
        repeat (3) tick();
        color = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total += 2;
        if (written !== 32'd1) begin bad++; $display("FAIL sr_written got %0d want 1", written); end
        if (clipped !== 32'd1) begin bad++; $display("FAIL sr_clipped got %0d want 1", clipped); end
        send_pixel(5, 4);
        finish_frame();
        total += 4;
        if (written !== 32'd2) begin bad++; $display("FAIL sr_final_written got %0d want 2", written); end
        if (clipped !== 32'd1) begin bad++; $display("FAIL sr_final_clipped got %0d want 1", clipped); end
        if (done !== 1'b1)     begin bad++; $display("FAIL sr_done got %0b want 1", done); end
        if (log_addr.size() - base !== 2) begin
            bad++; $display("FAIL sr_count got %0d want 2", log_addr.size() - base);
        end else begin
            total++;
            if (log_addr[base + 1] !== 19'd2565 || log_data[base + 1] !== 8'h77) begin
                bad++; $display("FAIL sr_last_write got addr=%0d data=%0h want addr=2565 data=77",
                                log_addr[base + 1], log_data[base + 1]);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        color     = 8'h00;
        in_x      = '0;
        in_y      = '0;
        in_valid  = 1'b0;
        in_done   = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_rect();
        test_clip();
        test_backpressure();
        test_reset_mid();
        test_empty();
        test_start_in_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pixel_writer
`default_nettype wire

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640: framebuffer width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480: framebuffer height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 19: memory address width; elaboration SHALL fail if 2**ADDR_W < SCREEN_W*SCREEN_H.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: pending-write buffer depth, power of two.
REQ-005 SHALL have these ports:
- _clock  in  1  sole clock; all logic on the rising edge.
- _reset_n  in  1  synchronous, active-low reset.
- _start  in  1  begins a frame and latches color.
- color  in  8  pixel value for the frame.
- _in_x  in  32  signed pixel x from the upstream shape generator.
- _in_y  in  32  signed pixel y.
- _in_valid  in  1  _in_x/_in_y valid.
- _in_ready  out  1  pixel accepted when _in_valid & _in_ready.
- _in_done  in  1  upstream generator finished (level).
- mem_addr  out  ADDR_W  write address = y*SCREEN_W + x.
- mem_data  out  8  write data, the latched color.
- mem_valid  out  1  write request.
- mem_ready  in  1  write accepted when mem_valid & mem_ready.
- written  out  32  in-bounds pixels written this frame.
- clipped  out  32  out-of-bounds pixels discarded this frame.
- _done  out  1  frame complete.

Function
REQ-006 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE/DONE -> RUN on _start=1; SHALL clear written/clipped, empty the FIFO and latch color on that edge.
REQ-008 RUN -> DRAIN when _in_done=1 and _in_valid=0; _start in RUN/DRAIN SHALL be ignored.
REQ-009 DRAIN -> DONE when the FIFO is empty and mem_valid=0.
REQ-010 _done SHALL be 1 only in DONE and SHALL hold until the next _start.
REQ-011 _in_ready SHALL equal (state==RUN && FIFO not full), with no combinational path from _in_x/_in_y/_in_valid.
REQ-012 An accepted pixel with 0<=x<SCREEN_W and 0<=y<SCREEN_H (signed compare) SHALL be pushed as address y*SCREEN_W+x, truncated to ADDR_W; otherwise clipped SHALL increment and nothing is pushed.
REQ-013 An in-bounds pixel accepted at edge N SHALL reach mem_valid no earlier than edge N+1; with mem_ready held high, throughput SHALL be one write per cycle.
REQ-014 While mem_valid=1 and mem_ready=0, mem_addr and mem_data SHALL be held stable.
REQ-015 written SHALL increment on each mem handshake.
REQ-016 written and clipped SHALL saturate at 2**32-1.
REQ-017 Writes SHALL issue in acceptance order.
REQ-018 A push and a pop in the same cycle SHALL be supported without changing occupancy.

Reset
REQ-019 _reset_n=0 at an edge SHALL force state IDLE, empty the FIFO, and clear the held color.
REQ-020 The same edge SHALL force mem_valid=0, _in_ready=0, _done=0, written=0, clipped=0, mem_addr=0 and mem_data=0.
REQ-021 Reset SHALL override a simultaneous _start, including mid-frame; no write SHALL issue after it.

Structure
REQ-022 Package pixel_writer_pkg SHALL hold the state enum plus default SCREEN_W/SCREEN_H/ADDR_W constants.
REQ-023 Buffering SHALL live in sub-module pixel_fifo: synchronous, registered output, with full/empty flags.

Verification
REQ-024 Rectangle perimeter: _start, color=8'hA5, 20 perimeter pixels of the 7x5 rectangle at (23,17), mem_ready=1 -> first mem_addr 10903, 20 writes, written=20, clipped=0, _done=1.
REQ-025 Clip: pixels (-1,0),(640,0),(0,480),(639,479) -> one write at addr 307199, clipped=3, written=1.
REQ-026 Backpressure: mem_ready=0 for 10 cycles with 6 pixels offered -> _in_ready drops once the 4-deep FIFO is full, mem_addr stable; after release all 6 written in order.
REQ-027 Reset mid-frame: _reset_n=0 for one cycle with 3 pending writes -> next cycle mem_valid=0, counters 0, IDLE, no further writes.
REQ-028 Empty frame: _start then _in_done=1 with no pixels -> _done=1 within 2 cycles, written=0.
REQ-029 _start pulsed during RUN -> counters unchanged, frame completes normally.
